fp_add_arbiter: RTL
===================

# fp_add_arbiter

- Shares one fixed-latency, fully pipelined FP_ADD instance among NREQ requesters using round-robin arbitration.
- Accepts at most one operand pair per cycle.
- Tags each issued operation with its requester ID and routes each result back to the originating requester.
- Sits between the memory-mapped data feeders and the single FP adder.

## Interface
- NREQ, 4: number of requesters (2..8).
- XLEN, 32: operand/result width.
- LAT, 11: FP_ADD latency in cycles, from s_axis valid to m_axis_result_tvalid.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- en_i  in  1  arbitration enable; low blocks new grants, in-flight ops complete.
- req_valid_i  in  NREQ  per-requester operand valid.
- req_a_i  in  NREQ*XLEN  operand A, requester i at bits [i*XLEN +: XLEN].
- req_b_i  in  NREQ*XLEN  operand B, same packing.
- req_ready_o  out  NREQ  grant, one-hot or zero; combinational from req_valid_i, pointer and en_i.
- add_valid_o  out  1  to FP_ADD s_axis_a_tvalid and s_axis_b_tvalid.
- add_a_o / add_b_o  out  XLEN each  to FP_ADD s_axis_a_tdata / s_axis_b_tdata.
- add_res_valid_i  in  1  FP_ADD m_axis_result_tvalid.
- add_res_i  in  XLEN  FP_ADD m_axis_result_tdata.
- resp_valid_o  out  NREQ  one-hot result strobe, one cycle; no backpressure.
- resp_data_o  out  XLEN  result, valid while any resp_valid_o bit is set.
- err_o  out  1  sticky tag/result mismatch flag.
- perf_issue_o  out  32  issued-op counter.
- perf_conflict_o  out  32  contention-cycle counter.

## Operation
**Arbitration**
- Pointer ptr (clog2(NREQ) bits) defines priority. Search order is ptr, ptr+1, …, wrapping modulo NREQ.
- The first requester in that order with req_valid_i set gets req_ready_o, provided en_i=1.
- Handshake completes when req_valid_i[i] & req_ready_o[i].
- On a handshake, ptr <= (i+1) mod NREQ. With no handshake, ptr holds.
- Requesters must hold req_valid_i and operands until ready. Dropping valid before a grant is legal; no op is issued.

**Issue stage (registered)**
- add_valid_o <= handshake.
- add_a_o and add_b_o <= granted operands, updated only on a handshake.
- tag_in <= {1'b1, i} on a handshake, else {1'b0, x}.

**Tag pipeline**
- Shift register of LAT entries, each {valid, id}. Entry k+1 <= entry k every cycle; tag_in enters entry 0.
- Entry LAT-1 aligns with add_res_valid_i.

**Return stage (registered)**
- When tag_out.valid & add_res_valid_i: resp_valid_o <= one-hot(tag_out.id) and resp_data_o <= add_res_i.
- Otherwise resp_valid_o <= 0, and resp_data_o holds.

**Error detection**
- err_o sets on tag_out.valid != add_res_valid_i.
- Suppressed during the first LAT+1 cycles after reset release, tracked by a warm-up counter.
- Cleared only by reset.
- A result with no tag is dropped. A tag with no result produces no response.

## Timing
**Reset values** (rst_ni=0 sampled on a rising edge):
- ptr=0; all tag entries invalid; warm-up counter=0.
- add_valid_o=0, add_a_o=0, add_b_o=0.
- resp_valid_o=0, resp_data_o=0, err_o=0.
- perf counters=0.
- req_ready_o=0 while rst_ni=0.

**Latency**
- Handshake in cycle t, add_valid_o in cycle t+1, resp_valid_o in cycle t+2+LAT.
- Throughput is 1 op/cycle. Back-to-back handshakes produce back-to-back responses in issue order.

**Boundary conditions**
- All NREQ valid: grants rotate, so each requester is served once per NREQ cycles.
- Single requester continuously valid: granted every cycle.
- ptr wraps from NREQ-1 to 0.
- en_i falling mid-stream: no grant that cycle. Tags already issued still return responses.
- Reset mid-operation: in-flight tags are discarded. Late adder results during warm-up are dropped without setting err_o.
- Same requester with multiple outstanding ops: allowed, and responses arrive in order.

## Configuration
Macro: FP_ARB_PERF_EN.

**Defined**
- perf_issue_o increments on every handshake.
- perf_conflict_o increments on every cycle with en_i=1 and two or more req_valid_i bits set.
- Both counters saturate at 32'hFFFFFFFF.

**Undefined**
- Counter logic is absent and both outputs are tied to 0.
- All other behaviour is identical.

## Test plan
- **Single op:** reset, then req0 valid with a=32'h3F800000, b=32'h40000000, en_i=1. Required: ready0 in the same cycle, add_valid_o one cycle later, resp_valid_o=4'b0001 with resp_data_o=32'h40400000 exactly LAT+2 cycles after the handshake.
- **Full contention:** all four requesters valid for 8 cycles from ptr=0. Required: grant order 0,1,2,3,0,1,2,3; responses one-hot in the same order; perf_conflict_o=8 with FP_ARB_PERF_EN defined.
- **Pointer wrap / partial requests:** only req1 and req3 valid. Required: grants alternate 1,3,1,3; ptr after the req3 grant is 0.
- **Enable gating:** en_i=0 for 3 cycles while req2 is valid. Required: no ready, no add_valid_o, ops issued earlier still return; en_i=1 grants req2 next cycle.
- **Reset mid-flight:** issue 3 ops, assert rst_ni=0 for 1 cycle, then let the model still return 3 results. Required: no resp_valid_o and err_o=0.
- **Mismatch:** after warm-up, force add_res_valid_i=1 with no tag outstanding. Required: err_o=1 next cycle, staying set until reset; no resp_valid_o.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// Requester, adder and response signals of the shared FP_ADD arbiter.
// The slave modport is the arbiter's view; master is its environment.
interface fp_add_arbiter_if #(
    parameter int NREQ = 4,
    parameter int XLEN = 32
);
    logic                 en_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*XLEN-1:0] req_a_i;
    logic [NREQ*XLEN-1:0] req_b_i;
    logic [NREQ-1:0]      req_ready_o;
    logic                 add_valid_o;
    logic [XLEN-1:0]      add_a_o;
    logic [XLEN-1:0]      add_b_o;
    logic                 add_res_valid_i;
    logic [XLEN-1:0]      add_res_i;
    logic [NREQ-1:0]      resp_valid_o;
    logic [XLEN-1:0]      resp_data_o;
    logic                 err_o;
    logic [31:0]          perf_issue_o;
    logic [31:0]          perf_conflict_o;

    modport slave (
        input  en_i, req_valid_i, req_a_i, req_b_i,
        input  add_res_valid_i, add_res_i,
        output req_ready_o, add_valid_o, add_a_o, add_b_o,
        output resp_valid_o, resp_data_o, err_o,
        output perf_issue_o, perf_conflict_o
    );

    modport master (
        output en_i, req_valid_i, req_a_i, req_b_i,
        output add_res_valid_i, add_res_i,
        input  req_ready_o, add_valid_o, add_a_o, add_b_o,
        input  resp_valid_o, resp_data_o, err_o,
        input  perf_issue_o, perf_conflict_o
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP_ADD among NREQ requesters.
// Define FP_ARB_PERF_EN to build the issue/contention counters.
module fp_add_arbiter #(
    parameter int NREQ = 4,
    parameter int XLEN = 32,
    parameter int LAT  = 11
) (
    input logic           clk_i,
    input logic           rst_ni,
    fp_add_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(LAT + 2);

    typedef struct packed {
        logic          v;
        logic [PW-1:0] id;
    } tag_t;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            gfound;
    logic [NREQ-1:0] grant;
    logic            hs;

    logic            add_valid;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;

    tag_t            tag_in;
    tag_t            tag_q [LAT];
    tag_t            tag_out;

    logic [NREQ-1:0] resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            err;
    logic [WW-1:0]   warm;
    logic            warm_done;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int j;
        j      = 0;
        gidx   = '0;
        gfound = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!gfound && bus.req_valid_i[j]) begin
                gfound = 1'b1;
                gidx   = PW'(j);
            end
        end
    end

    assign grant = (gfound && bus.en_i && rst_ni)
                 ? (NREQ'(1) << gidx) : '0;
    assign hs    = |(grant & bus.req_valid_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr       <= '0;
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            tag_in    <= '0;
        end else begin
            add_valid <= hs;
            tag_in    <= {hs, gidx};
            if (hs) begin
                ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                add_a <= bus.req_a_i[gidx*XLEN +: XLEN];
                add_b <= bus.req_b_i[gidx*XLEN +: XLEN];
            end
        end
    end

    // Tag shift register; last entry lines up with the adder result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tag_out   = tag_q[LAT-1];
    assign warm_done = (warm == WW'(LAT + 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid <= '0;
            resp_data  <= '0;
            err        <= 1'b0;
            warm       <= '0;
        end else begin
            if (!warm_done) begin
                warm <= warm + 1'b1;
            end
            if (warm_done && (tag_out.v != bus.add_res_valid_i)) begin
                err <= 1'b1;
            end
            if (tag_out.v && bus.add_res_valid_i) begin
                resp_valid <= NREQ'(1) << tag_out.id;
                resp_data  <= bus.add_res_i;
            end else begin
                resp_valid <= '0;
            end
        end
    end

    assign bus.req_ready_o  = grant;
    assign bus.add_valid_o  = add_valid;
    assign bus.add_a_o      = add_a;
    assign bus.add_b_o      = add_b;
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_data_o  = resp_data;
    assign bus.err_o        = err;

`ifdef FP_ARB_PERF_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_conflict;
    logic        contend;

    assign contend = bus.en_i && ($countones(bus.req_valid_i) > 1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_issue    <= '0;
            perf_conflict <= '0;
        end else begin
            if (hs && (perf_issue != '1)) begin
                perf_issue <= perf_issue + 1'b1;
            end
            if (contend && (perf_conflict != '1)) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end

    assign bus.perf_issue_o    = perf_issue;
    assign bus.perf_conflict_o = perf_conflict;
`else
    assign bus.perf_issue_o    = '0;
    assign bus.perf_conflict_o = '0;
`endif
endmodule
